alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle controller that sits in front of the 32-bit ALU datapath and sequences one operation at a time. It accepts an operation request over a valid/ready handshake and registers the operands. It holds the opcode and operands on the ALU for a per-operation number of cycles, then captures the 64-bit ALU result into the Z, HI and LO result registers. Multiply and divide get multi-cycle execute windows; all other operations complete in one execute cycle.

## Interface
Parameters:
- MUL_CYCLES, 4, execute cycles held for mul (legal range 1–15)
- DIV_CYCLES, 8, execute cycles held for div (legal range 1–15)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_op  in  5  opcode
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_a  out  32  registered operand A driven to ALU RA
- alu_b  out  32  registered operand B driven to ALU RB
- alu_op  out  5  registered opcode driven to ALU
- alu_rz  in  64  ALU result
  - mul: full product
  - div: {remainder, quotient}
  - others: result in [31:0]
- z_out  out  32  single-width result register
- hi_out  out  32  mul high word / div remainder
- lo_out  out  32  mul low word / div quotient
- done  out  1  one-cycle pulse; result registers are valid while it is high
- illegal  out  1  high with done when the accepted opcode was unsupported

## Operation
- Supported opcodes:
  - add 00000, sub 00001, mul 00010, div 00011
  - and 00100, or 00101
  - shr 00110, shra 00111, shl 01000, ror 01001, rol 01011
  - neg 01100, not 01101
- All other opcodes are illegal, including 01010 and 01110–11111.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, at the edge: register req_a/req_b/req_op into alu_a/alu_b/alu_op.
  - Legal opcode: load cnt=L-1 and go to EXEC.
  - Illegal opcode: set illegal=1 and go directly to DONE; Z/HI/LO are unchanged.
- L values: MUL_CYCLES for mul, DIV_CYCLES for div, 1 for all other opcodes.
- EXEC:
  - alu_a/alu_b/alu_op stay stable.
  - cnt decrements each cycle.
  - At the edge where cnt==0, capture the result and go to DONE.
    - mul/div: hi_out←alu_rz[63:32], lo_out←alu_rz[31:0].
    - Others: z_out←alu_rz[31:0].
  - The result registers not targeted by the opcode hold their value.
- DONE: done=1 for exactly one cycle, then IDLE. illegal clears when leaving DONE.
- Requests are ignored while req_ready=0; there is no queueing.
- Operand registers hold their last value after completion.

## Timing
- Reset state: IDLE, and every output is zero (alu_a, alu_b, alu_op, z_out, hi_out, lo_out, done, illegal). req_ready=1 from the first cycle after reset.
- Accept at edge E0. EXEC occupies the L cycles after E0. Result registers update at edge E_L. done is high between E_L and E_L+1.
- Illegal opcode: done and illegal are high between E0 and E1.
- Back-to-back: the next accept is possible at edge E_L+2. req_ready is low during both EXEC and DONE.
- Reset asserted during EXEC or DONE: the next edge returns to IDLE with all outputs zero. No done is emitted for the aborted operation.
- Reset overrides a simultaneous req_valid.
- alu_rz is sampled only at the final EXEC edge; the ALU is combinational with respect to the sequencer.

## Configuration
- ALU_SEQ_FLAGS_EN
  - Defined: adds outputs flag_zero (1 bit) and flag_neg (1 bit), registered at the result-capture edge.
    - Single-width ops: flags are computed from alu_rz[31:0].
    - mul/div: flags are computed from the 64-bit alu_rz.
    - Illegal ops: flags are unchanged.
    - Reset value 0.
  - Undefined: the ports and flag logic are absent; all other behaviour is identical.

## Test plan
- Reset, then add with A=5, B=7 → req_ready=1 after reset; z_out=12 with done high one cycle after the single EXEC cycle; hi_out/lo_out stay 0.
- mul with A=0x00010000, B=0x00010000, MUL_CYCLES=4 → done 4 cycles after accept edge; hi_out=1, lo_out=0; alu_op=00010 stable throughout EXEC; z_out unchanged.
- div with A=17, B=5, DIV_CYCLES=8 → lo_out=3, hi_out=2 at done; req_valid pulses during EXEC are ignored, with req_ready=0.
- Opcode 01010 → done and illegal high the cycle after accept; z_out/hi_out/lo_out unchanged.
- Reset asserted in the 3rd EXEC cycle of a div → IDLE next cycle; all outputs 0; no done pulse.
- With ALU_SEQ_FLAGS_EN: sub with A=3, B=3 → flag_zero=1, flag_neg=0. Then sub with A=2, B=3 → flag_zero=0, flag_neg=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer that registers one ALU operation, holds it for a per-opcode
// execute window and captures the 64-bit result. Optional flags: `define ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_rz,
  output logic [31:0] z_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        done,
  output logic        illegal
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic        flag_zero,
  output logic        flag_neg
`endif
);

  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       last_exec;
  logic       wide_op;

  // Opcode 01010 is a hole in the encoding; everything above 01101 is unused.
  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op) inside
      [5'd0:5'd9], [5'd11:5'd13]: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] exec_cnt_init(input logic [4:0] op);
    logic [3:0] c;
    c = 4'd0;
    if (op == OP_MUL)      c = 4'(MUL_CYCLES - 1);
    else if (op == OP_DIV) c = 4'(DIV_CYCLES - 1);
    return c;
  endfunction

  assign accept    = (state == ST_IDLE) && req_valid;
  assign last_exec = (state == ST_EXEC) && (cnt == 4'd0);
  assign wide_op   = (alu_op == OP_MUL) || (alu_op == OP_DIV);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = op_legal(req_op) ? ST_EXEC : ST_DONE;
      ST_EXEC: if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    done      = (state == ST_DONE);
  end

  // Operand, counter and result registers; all cleared by reset so an aborted
  // operation leaves nothing visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      cnt     <= '0;
      z_out   <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
      illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= req_a;
        alu_b   <= req_b;
        alu_op  <= req_op;
        cnt     <= exec_cnt_init(req_op);
        illegal <= ~op_legal(req_op);
      end
      if (state == ST_EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (last_exec) begin
        if (wide_op) begin
          hi_out <= alu_rz[63:32];
          lo_out <= alu_rz[31:0];
        end else begin
          z_out  <= alu_rz[31:0];
        end
      end
      if (state == ST_DONE) illegal <= 1'b0;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Flags follow the width of the captured result.
  always_ff @(posedge clock) begin
    if (reset) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (last_exec) begin
      if (wide_op) begin
        flag_zero <= (alu_rz == 64'd0);
        flag_neg  <= alu_rz[63];
      end else begin
        flag_zero <= (alu_rz[31:0] == 32'd0);
        flag_neg  <= alu_rz[31];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU driving alu_rz.
// Flag checks run when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_rz;
  logic [31:0] z_out, hi_out, lo_out;
  logic        done, illegal;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_zero, flag_neg;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010,
                         DIV = 5'b00011, SHL = 5'b01000;

  always #5 clock = ~clock;

  alu_op_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rz(alu_rz),
    .z_out(z_out), .hi_out(hi_out), .lo_out(lo_out),
    .done(done), .illegal(illegal)
`ifdef ALU_SEQ_FLAGS_EN
    , .flag_zero(flag_zero), .flag_neg(flag_neg)
`endif
  );

  // Combinational ALU stand-in.
  always_comb begin
    alu_rz = 64'd0;
    case (alu_op)
      5'b00000: alu_rz[31:0] = alu_a + alu_b;
      5'b00001: alu_rz[31:0] = alu_a - alu_b;
      5'b00010: alu_rz = {32'd0, alu_a} * {32'd0, alu_b};
      5'b00011: if (alu_b != 0) alu_rz = {alu_a % alu_b, alu_a / alu_b};
      5'b00100: alu_rz[31:0] = alu_a & alu_b;
      5'b00101: alu_rz[31:0] = alu_a | alu_b;
      5'b00110: alu_rz[31:0] = alu_a >> alu_b[4:0];
      5'b00111: alu_rz[31:0] = $signed(alu_a) >>> alu_b[4:0];
      5'b01000: alu_rz[31:0] = alu_a << alu_b[4:0];
      5'b01100: alu_rz[31:0] = -alu_a;
      5'b01101: alu_rz[31:0] = ~alu_a;
      default:  alu_rz = 64'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"},   alu_a,   0);
    check({tag, "_alu_b"},   alu_b,   0);
    check({tag, "_alu_op"},  alu_op,  0);
    check({tag, "_z"},       z_out,   0);
    check({tag, "_hi"},      hi_out,  0);
    check({tag, "_lo"},      lo_out,  0);
    check({tag, "_done"},    done,    0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_ready"},   req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    step(); step();
    check_all_zero("rst");
`ifdef ALU_SEQ_FLAGS_EN
    check("rst_fz", flag_zero, 0);
    check("rst_fn", flag_neg, 0);
`endif
    reset = 1'b0;

    // add: one EXEC cycle, result at E1
    issue(ADD, 32'd5, 32'd7);
    check("add_ready_exec", req_ready, 0);
    check("add_done_exec", done, 0);
    check("add_alu_a", alu_a, 5);
    check("add_alu_b", alu_b, 7);
    check("add_alu_op", alu_op, ADD);
    step();
    check("add_done", done, 1);
    check("add_z", z_out, 12);
    check("add_hi", hi_out, 0);
    check("add_lo", lo_out, 0);
    check("add_illegal", illegal, 0);
    step();
    check("add_done_clear", done, 0);
    check("add_ready_back", req_ready, 1);

    // mul: four EXEC cycles
    issue(MUL, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 4; i++) begin
      check("mul_op_stable", alu_op, MUL);
      check("mul_no_early_done", done, 0);
      step();
    end
    check("mul_done", done, 1);
    check("mul_hi", hi_out, 1);
    check("mul_lo", lo_out, 0);
    check("mul_z_hold", z_out, 12);
    step();

    // div: eight EXEC cycles, stray request mid-way must be ignored
    issue(DIV, 32'd17, 32'd5);
    for (int i = 0; i < 8; i++) begin
      check("div_ready_low", req_ready, 0);
      check("div_no_early_done", done, 0);
      if (i == 2) begin
        req_valid = 1'b1; req_op = ADD; req_a = 32'd99; req_b = 32'd1;
      end
      step();
      req_valid = 1'b0;
    end
    check("div_done", done, 1);
    check("div_lo", lo_out, 3);
    check("div_hi", hi_out, 2);
    check("div_z_hold", z_out, 12);
    check("div_alu_a_hold", alu_a, 17);
    check("div_alu_op_hold", alu_op, DIV);
    step();
    check("div_done_clear", done, 0);

    // shl single-width, hi/lo hold
    issue(SHL, 32'd1, 32'd4);
    step();
    check("shl_done", done, 1);
    check("shl_z", z_out, 16);
    check("shl_hi_hold", hi_out, 2);
    check("shl_lo_hold", lo_out, 3);
    step();

    // illegal hole 01010: done+illegal right after accept
    issue(5'b01010, 32'd8, 32'd9);
    check("ill_done", done, 1);
    check("ill_flag", illegal, 1);
    check("ill_alu_op", alu_op, 5'b01010);
    check("ill_z_hold", z_out, 16);
    check("ill_hi_hold", hi_out, 2);
    check("ill_lo_hold", lo_out, 3);
    step();
    check("ill_done_clear", done, 0);
    check("ill_flag_clear", illegal, 0);
    check("ill_ready", req_ready, 1);

    issue(5'b11111, 32'd1, 32'd1);
    check("ill_top_flag", illegal, 1);
    check("ill_top_done", done, 1);
    step();

    // sub producing zero, then negative
    issue(SUB, 32'd3, 32'd3);
    step();
    check("sub0_z", z_out, 0);
`ifdef ALU_SEQ_FLAGS_EN
    check("sub0_fz", flag_zero, 1);
    check("sub0_fn", flag_neg, 0);
`endif
    step();
    issue(SUB, 32'd2, 32'd3);
    step();
    check("subn_z", z_out, 32'hFFFF_FFFF);
`ifdef ALU_SEQ_FLAGS_EN
    check("subn_fz", flag_zero, 0);
    check("subn_fn", flag_neg, 1);
`endif
    step();

    // reset in the third EXEC cycle of a div aborts it
    issue(DIV, 32'd100, 32'd7);
    step(); step();
    reset = 1'b1;
    step();
    check_all_zero("abort");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done", done, 0);
      step();
    end

    // reset wins over a simultaneous request
    reset = 1'b1; req_valid = 1'b1; req_op = ADD; req_a = 32'd5; req_b = 32'd5;
    step();
    check("ovr_alu_a", alu_a, 0);
    check("ovr_ready", req_ready, 1);
    reset = 1'b0; req_valid = 1'b0;
    step();
    check("ovr_no_done", done, 0);
    check("ovr_z", z_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
